mul_arbiter_seq: RTL and testbench
==================================

// Module: mul_arbiter_seq
// PURPOSE
//  Shares one iterative shift-add multiplier between two requesters (e.g. ALU
//  MUL op and address-scaling unit) of the 16-bit CPU. Arbitrates round-robin,
//  captures operands, computes a 2*WIDTH-bit product over WIDTH cycles, and
//  returns it tagged with the requester id on a valid/ready result port.
// PARAMETERS
//  WIDTH   16   operand width; product is 2*WIDTH bits
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  req0_valid   in   1        requester 0 has operands
//  req0_ready   out  1        requester 0 operands accepted this cycle
//  req0_a       in   WIDTH    requester 0 multiplicand
//  req0_b       in   WIDTH    requester 0 multiplier
//  req1_valid   in   1        requester 1 has operands
//  req1_ready   out  1        requester 1 operands accepted this cycle
//  req1_a       in   WIDTH    requester 1 multiplicand
//  req1_b       in   WIDTH    requester 1 multiplier
//  res_valid    out  1        product valid
//  res_ready    in   1        consumer takes product
//  res_id       out  1        requester that owns res_product
//  res_product  out  2*WIDTH  product
//  busy         out  1        high in CALC or DONE
// BEHAVIOUR
//  - Single clock clk; reset rst_n asynchronous, active-low. In reset: state=IDLE,
//    res_valid=0, res_id=0, res_product=0, busy=0, counter=0, last_grant=1.
//  - States: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: reqN_ready is combinational, high only for the granted requester,
//    only in IDLE. Grant: only one valid -> that one; both valid -> the one
//    != last_grant. Transfer = valid & ready; latch a, b, id; last_grant=id;
//    acc=0; counter=0; -> CALC. No valid -> stay IDLE.
//  - CALC: one multiplier bit per cycle, LSB first: if b[0] acc += a<<counter;
//    b>>=1; counter++. After exactly WIDTH CALC cycles -> DONE (no early exit
//    on b==0; latency is data-independent).
//  - Latency: res_valid rises WIDTH rising edges after the accept edge.
//  - DONE: res_valid=1; res_product/res_id stable until res_ready. valid &
//    ready -> IDLE, res_valid drops next edge. Next accept no earlier than
//    the cycle after return to IDLE (throughput 1 per WIDTH+2 cycles).
//  - Requests arriving in CALC/DONE are not acknowledged (ready=0); requester
//    holds valid and operands stable until ready.
//  - Arithmetic: product modulo 2^(2*WIDTH), never overflows; a=0 or b=0 -> 0.
//  - res_product keeps last value after handshake until next DONE.
//  - rst_n asserted mid-CALC/DONE: operation dropped, no result issued,
//    outputs to reset values asynchronously.
// CONFIGURATION
//  MUL_SIGNED_EN defined: operands two's complement. Accept latches |a|,|b|
//    and sign=a[W-1]^b[W-1]; DONE output negated if sign. Latency unchanged.
//    -32768 * -32768 = 32'h4000_0000; -1 * 1 = 32'hFFFF_FFFF.
//  MUL_SIGNED_EN undefined: unsigned; 16'hFFFF*16'hFFFF = 32'hFFFE_0001.
// TESTING
//  1 req0 a=3,b=5, res_ready=1 -> req0_ready 1 cycle, res_valid after 16
//    edges, res_product=15, res_id=0, busy high through DONE.
//  2 req0 & req1 valid same cycle from reset -> req0 granted first, then
//    req1; results in order id 0 then id 1; third simultaneous request -> req0.
//  3 unsigned FFFF*FFFF -> FFFE_0001; 0*1234 -> 0 still after 16 edges.
//  4 res_ready held 0 for 10 cycles in DONE -> res_valid, product, id stable,
//    req1_valid high throughout gets no ready until after result handshake.
//  5 rst_n low at CALC cycle 7 -> res_valid/busy 0 at once, no result issued,
//    after release a new req0 request completes normally.
//  6 MUL_SIGNED_EN: -3*5 -> FFFF_FFF1; 8000*8000 -> 4000_0000; -1*-1 -> 1.

Source files
------------

// File: rtl/mul_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter_seq
// Purpose  : Round-robin arbiter in front of one shift-add multiplier.
//            It returns a 2*WIDTH product tagged with the requester id.
//            Define MUL_SIGNED_EN to treat the operands as two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module mul_arbiter_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_id,
   output logic [2*WIDTH-1:0] res_product,
   output logic               busy
);

   localparam int               c_cnt_w   = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_id;
   logic                 r_last_grant;

   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_take0;
   logic                 w_take1;
   logic [WIDTH-1:0]     w_sel_a;
   logic [WIDTH-1:0]     w_sel_b;
   logic [WIDTH-1:0]     w_opnd_a;
   logic [WIDTH-1:0]     w_opnd_b;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_result;

   // On a tie the requester that did not win last time is served.
   assign w_grant0   = req0_valid & (~req1_valid | r_last_grant);
   assign w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
   assign req0_ready = (r_state == ST_IDLE) & w_grant0;
   assign req1_ready = (r_state == ST_IDLE) & w_grant1;
   assign w_take0    = req0_valid & req0_ready;
   assign w_take1    = req1_valid & req1_ready;

   assign w_sel_a    = w_grant1 ? req1_a : req0_a;
   assign w_sel_b    = w_grant1 ? req1_b : req0_b;
   assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef MUL_SIGNED_EN
   logic r_sign;
   logic w_sign;

   // The most negative operand's magnitude still fits as an unsigned value.
   assign w_opnd_a = w_sel_a[WIDTH-1] ? ((~w_sel_a) + WIDTH'(1)) : w_sel_a;
   assign w_opnd_b = w_sel_b[WIDTH-1] ? ((~w_sel_b) + WIDTH'(1)) : w_sel_b;
   assign w_sign   = w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1];
   assign w_result = r_sign ? ((~w_acc_next) + (2*WIDTH)'(1)) : w_acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign <= 1'b0;
      end else if ((r_state == ST_IDLE) && (w_take0 || w_take1)) begin
         r_sign <= w_sign;
      end
   end
`else
   assign w_opnd_a = w_sel_a;
   assign w_opnd_b = w_sel_b;
   assign w_result = w_acc_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         res_valid    <= 1'b0;
         res_id       <= 1'b0;
         res_product  <= '0;
         busy         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take0 || w_take1) begin
                  r_a          <= {{WIDTH{1'b0}}, w_opnd_a};
                  r_b          <= w_opnd_b;
                  r_acc        <= '0;
                  r_cnt        <= '0;
                  r_id         <= w_take1;
                  r_last_grant <= w_take1;
                  busy         <= 1'b1;
                  r_state      <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_acc <= w_acc_next;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + c_cnt_one;
               // Fixed WIDTH iterations so latency never depends on the data.
               if (r_cnt == c_cnt_last) begin
                  res_product <= w_result;
                  res_id      <= r_id;
                  res_valid   <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_arbiter_seq
// Purpose  : Directed self-checking bench for mul_arbiter_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter_seq;

   logic        clk;
   logic        rst_n;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        res_valid;
   logic        res_ready;
   logic        res_id;
   logic [31:0] res_product;
   logic        busy;

   int n_cmp;
   int n_err;
   logic seen;

   mul_arbiter_seq #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_id      (res_id),
      .res_product (res_product),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Entered just after the accept edge; result must appear 16 edges later.
   task automatic wait_result(input string tag, input logic id, input logic [31:0] exp);
      repeat (15) tick();
      check({tag, "_early"}, {31'd0, res_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, "_prod"}, res_product, exp);
      check({tag, "_id"}, {31'd0, res_id}, {31'd0, id});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
      req0_valid = 1'b1;
      req0_a     = a;
      req0_b     = b;
      #1;
      check({tag, "_rdy0"}, {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      #1;
      check({tag, "_bsy"}, {31'd0, busy}, 32'd1);
      check({tag, "_rdyc"}, {31'd0, req0_ready}, 32'd0);
      wait_result(tag, 1'b0, exp);
      tick();
      check({tag, "_drop"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_keep"}, res_product, exp);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req0_a     = '0;
      req0_b     = '0;
      req1_valid = 1'b0;
      req1_a     = '0;
      req1_b     = '0;
      res_ready  = 1'b1;
      tick();
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_id", {31'd0, res_id}, 32'd0);
      check("rst_prod", res_product, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdy0", {31'd0, req0_ready}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run_one("t1", 16'd3, 16'd5, 32'd15);

`ifndef MUL_SIGNED_EN
      run_one("t3_max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
`endif
      run_one("t3_zero", 16'd0, 16'h1234, 32'd0);

      // Consumer stalls in DONE while requester 1 waits.
      res_ready  = 1'b0;
      req0_valid = 1'b1;
      req0_a     = 16'd7;
      req0_b     = 16'd9;
      #1;
      check("t4_rdy0", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_a     = 16'h1234;
      req1_b     = 16'h0010;
      #1;
      check("t4_rdy1_calc", {31'd0, req1_ready}, 32'd0);
      wait_result("t4a", 1'b0, 32'd63);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_hold_valid", {31'd0, res_valid}, 32'd1);
         check("t4_hold_prod", res_product, 32'd63);
         check("t4_hold_id", {31'd0, res_id}, 32'd0);
         check("t4_hold_rdy1", {31'd0, req1_ready}, 32'd0);
      end
      res_ready = 1'b1;
      #1;
      check("t4_rdy1_done", {31'd0, req1_ready}, 32'd0);
      tick();
      check("t4_rdy1_idle", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      wait_result("t4b", 1'b1, 32'h0001_2340);
      tick();
      check("t4_drop", {31'd0, res_valid}, 32'd0);

      // Reset in the middle of a calculation.
      req0_valid = 1'b1;
      req0_a     = 16'd11;
      req0_b     = 16'd13;
      tick();
      req0_valid = 1'b0;
      repeat (6) tick();
      check("t5_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", {31'd0, res_valid}, 32'd0);
      check("t5_async_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | res_valid;
      end
      check("t5_no_result", {31'd0, seen}, 32'd0);
      run_one("t5_after", 16'd11, 16'd13, 32'd143);

      // Arbitration from reset: req0, req1, then req0 again on a tie.
      do_reset();
      req0_valid = 1'b1;
      req0_a     = 16'd3;
      req0_b     = 16'd4;
      req1_valid = 1'b1;
      req1_a     = 16'd6;
      req1_b     = 16'd7;
      #1;
      check("t2_g0_rdy0", {31'd0, req0_ready}, 32'd1);
      check("t2_g0_rdy1", {31'd0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      check("t2_calc_rdy1", {31'd0, req1_ready}, 32'd0);
      wait_result("t2a", 1'b0, 32'd12);
      tick();
      check("t2_g1_rdy1", {31'd0, req1_ready}, 32'd1);
      check("t2_g1_rdy0", {31'd0, req0_ready}, 32'd0);
      tick();
      req1_valid = 1'b0;
      wait_result("t2b", 1'b1, 32'd42);
      tick();
      req0_valid = 1'b1;
      req0_a     = 16'd2;
      req0_b     = 16'd2;
      req1_valid = 1'b1;
      req1_a     = 16'd5;
      req1_b     = 16'd5;
      #1;
      check("t2_g2_rdy0", {31'd0, req0_ready}, 32'd1);
      check("t2_g2_rdy1", {31'd0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      wait_result("t2c", 1'b0, 32'd4);
      tick();
      check("t2_g3_rdy1", {31'd0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      wait_result("t2d", 1'b1, 32'd25);
      tick();

`ifdef MUL_SIGNED_EN
      run_one("t6_neg", 16'hFFFD, 16'd5, 32'hFFFF_FFF1);
      run_one("t6_min", 16'h8000, 16'h8000, 32'h4000_0000);
      run_one("t6_m1m1", 16'hFFFF, 16'hFFFF, 32'd1);
      run_one("t6_m1p1", 16'hFFFF, 16'd1, 32'hFFFF_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
